// File: rtl/max7219_frame_sequencer.sv
// max7219_frame_sequencer
// Produces every register write the MAX7219 needs: the power-up initialisation
// words, an intensity word whenever the requested brightness changes, and one
// frame of digit words per refresh request. Words go to the serial shift-out
// engine over a valid/ready handshake. At most one word is in flight at a time.
module max7219_frame_sequencer #(
    parameter int         NUM_DIGITS  = 8,
    parameter logic [7:0] DECODE_MODE = 8'h00
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_ena,
    input  logic        i_refresh_stb,
    input  logic [63:0] i_digits,
    input  logic [3:0]  i_intensity,
    output logic        o_tx_valid,
    output logic [15:0] o_tx_data,
    input  logic        i_tx_ready,
    output logic        o_init_done,
    output logic        o_busy,
    output logic        o_frame_done_stb
);

    localparam logic [1:0] ST_INIT   = 2'd0;
    localparam logic [1:0] ST_IDLE   = 2'd1;
    localparam logic [1:0] ST_INTENS = 2'd2;
    localparam logic [1:0] ST_FRAME  = 2'd3;

    localparam logic [2:0] INIT_LAST      = 3'd4;
    localparam logic [2:0] INIT_INTENS_IX = 3'd3;
    localparam logic [2:0] FRAME_LAST     = 3'(NUM_DIGITS - 1);
    localparam logic [7:0] SCAN_LIMIT     = 8'(NUM_DIGITS - 1);

    // Initialisation word table; the intensity entry takes the live request.
    function automatic logic [15:0] init_word(input logic [2:0] idx,
                                              input logic [3:0] intens);
        logic [15:0] w;
        case (idx)
            3'd0:    w = 16'h0F00;
            3'd1:    w = {8'h0B, SCAN_LIMIT};
            3'd2:    w = {8'h09, DECODE_MODE};
            3'd3:    w = {8'h0A, 4'h0, intens};
            default: w = 16'h0C01;
        endcase
        return w;
    endfunction

    // Digit word: register address is digit index + 1, data is its segment byte.
    function automatic logic [15:0] digit_word(input logic [2:0]  idx,
                                               input logic [63:0] digits);
        logic [7:0] addr;
        addr = {5'd0, idx} + 8'd1;
        return {addr, digits[{idx, 3'b000} +: 8]};
    endfunction

    function automatic logic [15:0] intens_word(input logic [3:0] intens);
        return {8'h0A, 4'h0, intens};
    endfunction

    logic [1:0]  state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        valid_q, valid_d;
    logic [15:0] data_q, data_d;
    logic        init_done_q, init_done_d;
    logic        done_stb_q, done_stb_d;
    logic        pend_q, pend_d;
    logic [3:0]  intens_q, intens_d;
    logic [63:0] snap_q, snap_d;
    logic        accept;
    logic        take_frame;

    assign accept = valid_q & i_tx_ready;

    // Next-state logic: word loading, sequence stepping and work selection.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        valid_d     = valid_q;
        data_d      = data_q;
        init_done_d = init_done_q;
        done_stb_d  = 1'b0;
        intens_d    = intens_q;
        snap_d      = snap_q;
        take_frame  = 1'b0;

        case (state_q)
            ST_INIT: begin
                if (accept) begin
                    if (cnt_q == INIT_INTENS_IX) begin
                        intens_d = data_q[3:0];
                    end
                    if (cnt_q == INIT_LAST) begin
                        valid_d     = 1'b0;
                        init_done_d = 1'b1;
                        cnt_d       = 3'd0;
                        state_d     = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                        if (i_ena) begin
                            data_d = init_word(cnt_q + 3'd1, i_intensity);
                        end else begin
                            valid_d = 1'b0;
                        end
                    end
                end else if (!valid_q && i_ena) begin
                    valid_d = 1'b1;
                    data_d  = init_word(cnt_q, i_intensity);
                end
            end

            ST_IDLE: begin
                if (i_ena) begin
                    if (i_intensity != intens_q) begin
                        valid_d = 1'b1;
                        data_d  = intens_word(i_intensity);
                        state_d = ST_INTENS;
                    end else if (pend_q || i_refresh_stb) begin
                        // A strobe this cycle starts the frame directly, so the
                        // first digit word is built from the live input while the
                        // snapshot is captured for the rest of the frame.
                        take_frame = 1'b1;
                        snap_d     = i_digits;
                        cnt_d      = 3'd0;
                        valid_d    = 1'b1;
                        data_d     = digit_word(3'd0, i_digits);
                        state_d    = ST_FRAME;
                    end
                end
            end

            ST_INTENS: begin
                if (accept) begin
                    intens_d = data_q[3:0];
                    valid_d  = 1'b0;
                    state_d  = ST_IDLE;
                end
            end

            default: begin
                if (accept) begin
                    if (cnt_q == FRAME_LAST) begin
                        valid_d    = 1'b0;
                        done_stb_d = 1'b1;
                        cnt_d      = 3'd0;
                        state_d    = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                        if (i_ena) begin
                            data_d = digit_word(cnt_q + 3'd1, snap_q);
                        end else begin
                            valid_d = 1'b0;
                        end
                    end
                end else if (!valid_q && i_ena) begin
                    valid_d = 1'b1;
                    data_d  = digit_word(cnt_q, snap_q);
                end
            end
        endcase
    end

    // One-deep refresh request. A strobe that itself starts a frame is consumed;
    // a strobe landing while an older request is being consumed stays queued.
    always_comb begin
        pend_d = pend_q;
        if (pend_q) begin
            pend_d = take_frame ? i_refresh_stb : 1'b1;
        end else begin
            pend_d = i_refresh_stb & ~take_frame;
        end
    end

    // State registers; reset aborts any sequence and restarts initialisation.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q     <= ST_INIT;
            cnt_q       <= 3'd0;
            valid_q     <= 1'b0;
            data_q      <= 16'h0000;
            init_done_q <= 1'b0;
            done_stb_q  <= 1'b0;
            pend_q      <= 1'b0;
            intens_q    <= 4'h0;
            snap_q      <= 64'h0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            valid_q     <= valid_d;
            data_q      <= data_d;
            init_done_q <= init_done_d;
            done_stb_q  <= done_stb_d;
            pend_q      <= pend_d;
            intens_q    <= intens_d;
            snap_q      <= snap_d;
        end
    end

    assign o_tx_valid       = valid_q;
    assign o_tx_data        = data_q;
    assign o_init_done      = init_done_q;
    assign o_busy           = (state_q != ST_IDLE);
    assign o_frame_done_stb = done_stb_q;

endmodule
